// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states, widths and the queued command record shared by the ALU issue controller
package alu_pkg;
    localparam int OPW = 3;
    localparam int DW  = 4;
    localparam int RW  = 8;
    typedef enum logic [OPW-1:0] {
        OP_OR   = 3'b000,
        OP_NAND = 3'b001,
        OP_XOR  = 3'b010,
        OP_MUL  = 3'b011,
        OP_ADD  = 3'b100,
        OP_INC  = 3'b101,
        OP_SUB  = 3'b110,
        OP_SHR  = 3'b111
    } op_t;
    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;
    typedef struct packed {
        op_t           op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } cmd_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: in-order command queue of DEPTH 11-bit {op,a,b} entries, no bypass paths
// ports: clk, reset (async, active-high), push/wdata write side, pop/rdata head side, full, empty, count
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  cmd_t                   wdata,
    input  logic                   pop,
    output cmd_t                   rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    cmd_t          mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rp];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= wdata;
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues ALU commands, drives an external ALU for SETTLE cycles, then holds the captured result
// ports: clk, reset (async, active-high); cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b command in;
//        alu_a/alu_b/alu_s to the ALU, alu_r from it; rsp_valid/rsp_ready/rsp_r/rsp_op response out; busy
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [OPW-1:0] cmd_op,
    input  logic [DW-1:0]  cmd_a,
    input  logic [DW-1:0]  cmd_b,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_s,
    input  logic [RW-1:0]  alu_r,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [RW-1:0]  rsp_r,
    output logic [OPW-1:0] rsp_op,
    output logic           busy
);
    localparam int SW = $clog2(SETTLE + 1);
    state_t                 state;
    logic [SW-1:0]          cnt;
    cmd_t                   head, cmd_in;
    logic                   full, empty, pop;
    logic [$clog2(DEPTH):0] count;
    assign cmd_in    = {cmd_op, cmd_a, cmd_b};
    assign cmd_ready = !full;
    assign pop       = state == IDLE && !empty;
    assign busy      = count != '0 || state != IDLE;
    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .wdata (cmd_in),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            rsp_r     <= '0;
            rsp_op    <= '0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    alu_a <= head.a;
                    alu_b <= head.b;
                    alu_s <= head.op;
                    cnt   <= '0;
                    state <= DRIVE;
                end
                DRIVE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == SW'(SETTLE - 1)) begin
                        // only a product can legitimately use the upper result nibble
                        rsp_r     <= alu_s == OP_MUL ? alu_r : {4'h0, alu_r[3:0]};
                        rsp_op    <= alu_s;
                        rsp_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: table vectors plus corner sequences, responses checked against a scoreboard queue
module tb_alu_issue_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_a = '0, cmd_b = '0;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_s;
    logic [7:0] alu_r;
    logic       rsp_valid, rsp_ready = 1'b0;
    logic [7:0] rsp_r;
    logic [2:0] rsp_op;
    logic       busy;
    int         n_vec = 0, n_err = 0, n_rsp = 0;
    logic [7:0] cmd_exp = '0;
    logic [10:0] q[$];

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] r;
    } vec_t;
    vec_t tv[10];

    alu_issue_ctrl #(.DEPTH(4), .SETTLE(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_r     (alu_r),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_r     (rsp_r),
        .rsp_op    (rsp_op),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // external 4-bit ALU; several ops deliberately leave junk in the upper nibble
    always_comb begin
        alu_r = 8'h00;
        case (alu_s)
            3'b000: alu_r = {4'h0, alu_a | alu_b};
            3'b001: alu_r = ~{4'h0, alu_a & alu_b};
            3'b010: alu_r = {4'h0, alu_a ^ alu_b};
            3'b011: alu_r = {4'h0, alu_a} * {4'h0, alu_b};
            3'b100: alu_r = {4'h0, alu_a} + {4'h0, alu_b};
            3'b101: alu_r = {4'h0, alu_a} + 8'h01;
            3'b110: alu_r = {4'h0, alu_a} - {4'h0, alu_b};
            default: alu_r = {5'b10100, alu_a[3:1]};
        endcase
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // handshakes are decided by values stable across the next rising edge
    always @(negedge clk) begin
        if (reset) q.delete();
        else begin
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                if (q.size() == 0) chk("unexpected_rsp", rsp_r, 8'hxx);
                else begin
                    logic [10:0] e;
                    e = q.pop_front();
                    chk("rsp_r", rsp_r, e[7:0]);
                    chk("rsp_op", {5'b0, rsp_op}, {5'b0, e[10:8]});
                end
            end
            if (cmd_valid && cmd_ready) q.push_back({cmd_op, cmd_exp});
        end
    end

    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic [7:0] r);
        logic ok;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_exp = r; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = cmd_ready;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (!ok) chk("send_timeout", 8'd0, 8'd1);
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 50 && !rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        chk(nm, {7'b0, rsp_valid}, 8'd1);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 400 && (q.size() != 0 || busy); i++) begin
            @(posedge clk); #1;
        end
        chk(nm, 8'(q.size()), 8'd0);
        chk({nm, "_busy"}, {7'b0, busy}, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic seen;
        tv[0] = '{3'b000, 4'h5, 4'hA, 8'h0F};
        tv[1] = '{3'b001, 4'hC, 4'hA, 8'h07};
        tv[2] = '{3'b010, 4'h6, 4'h3, 8'h05};
        tv[3] = '{3'b011, 4'h3, 4'h7, 8'h15};
        tv[4] = '{3'b100, 4'h9, 4'h8, 8'h01};
        tv[5] = '{3'b101, 4'hF, 4'h0, 8'h00};
        tv[6] = '{3'b110, 4'h3, 4'h5, 8'h0E};
        tv[7] = '{3'b111, 4'h9, 4'h0, 8'h04};
        tv[8] = '{3'b011, 4'hF, 4'hF, 8'hE1};
        tv[9] = '{3'b100, 4'h7, 4'h8, 8'h0F};

        #1 reset = 1'b1;
        #1;
        chk("rst_cmd_ready", {7'b0, cmd_ready}, 8'd1);
        chk("rst_busy", {7'b0, busy}, 8'd0);
        chk("rst_rsp_valid", {7'b0, rsp_valid}, 8'd0);
        chk("rst_alu", {alu_s, alu_a, 1'b0}, 8'd0);
        chk("rst_rsp", rsp_r | {5'b0, rsp_op}, 8'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        rsp_ready = 1'b1;

        // first-result latency: valid after the third edge counting the accepting one
        send(3'b011, 4'hF, 4'hF, 8'hE1);
        chk("lat_e1", {7'b0, rsp_valid}, 8'd0);
        @(posedge clk); #1;
        chk("lat_e2", {7'b0, rsp_valid}, 8'd0);
        chk("drive_alu_s", {5'b0, alu_s}, 8'd3);
        @(posedge clk); #1;
        chk("lat_e3", {7'b0, rsp_valid}, 8'd1);
        chk("lat_r", rsp_r, 8'hE1);
        chk("lat_op", {5'b0, rsp_op}, 8'd3);
        drain("lat_drain");

        foreach (tv[i]) send(tv[i].op, tv[i].a, tv[i].b, tv[i].r);
        drain("table_drain");
        chk("alu_hold_a", {4'h0, alu_a}, 8'h7);

        // stall: five accepted, sixth refused, head response frozen
        rsp_ready = 1'b0;
        base = n_rsp;
        send(3'b011, 4'h2, 4'h3, 8'h06);
        send(3'b010, 4'hF, 4'h0, 8'h0F);
        send(3'b100, 4'hF, 4'hF, 8'h0E);
        send(3'b101, 4'h7, 4'h0, 8'h08);
        send(3'b111, 4'h8, 4'h0, 8'h04);
        cmd_op = 3'b000; cmd_a = 4'h1; cmd_b = 4'h1; cmd_exp = 8'h01; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_cmd_ready", {7'b0, cmd_ready}, 8'd0);
            chk("stall_rsp_r", rsp_r, 8'h06);
            chk("stall_valid", {7'b0, rsp_valid}, 8'd1);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        drain("stall_drain");
        chk("stall_count", 8'(n_rsp - base), 8'd5);

        // push on the same edge the IDLE state pops a single queued entry
        rsp_ready = 1'b0;
        base = n_rsp;
        send(3'b000, 4'h1, 4'h2, 8'h03);
        send(3'b110, 4'h9, 4'h1, 8'h08);
        wait_valid("pp_hold");
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        send(3'b010, 4'h5, 4'hA, 8'h0F);
        drain("pp_drain");
        chk("pp_count", 8'(n_rsp - base), 8'd3);

        // reset while holding a response with three queued
        rsp_ready = 1'b0;
        send(3'b100, 4'h1, 4'h1, 8'h02);
        send(3'b100, 4'h2, 4'h2, 8'h04);
        send(3'b100, 4'h3, 4'h3, 8'h06);
        send(3'b100, 4'h4, 4'h4, 8'h08);
        wait_valid("mr_hold");
        #3 reset = 1'b1;
        #1;
        chk("mr_rsp_valid", {7'b0, rsp_valid}, 8'd0);
        chk("mr_busy", {7'b0, busy}, 8'd0);
        chk("mr_cmd_ready", {7'b0, cmd_ready}, 8'd1);
        chk("mr_alu", {alu_s, alu_a, 1'b0} | {4'h0, alu_b}, 8'd0);
        chk("mr_rsp", rsp_r | {5'b0, rsp_op}, 8'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen |= rsp_valid | busy;
            @(posedge clk); #1;
        end
        chk("mr_no_stale", {7'b0, seen}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 Parameter SETTLE, default 1, cycles ALU operands are held before the result is captured (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command FIFO can accept.
REQ-007 cmd_op  input  3  opcode: OR=000, NAND=001, XOR=010, MUL=011, ADD=100, INC=101, SUB=110, SHR=111.
REQ-008 cmd_a  input  4  operand A.
REQ-009 cmd_b  input  4  operand B.
REQ-010 alu_a  output  4  registered operand A driven to the downstream ALU.
REQ-011 alu_b  output  4  registered operand B driven to the ALU.
REQ-012 alu_s  output  3  registered opcode driven to the ALU select.
REQ-013 alu_r  input  8  combinational ALU result.
REQ-014 rsp_valid  output  1  response held valid.
REQ-015 rsp_ready  input  1  consumer accepts response.
REQ-016 rsp_r  output  8  captured result.
REQ-017 rsp_op  output  3  opcode of that result.
REQ-018 busy  output  1  high when the FIFO is non-empty or state is not IDLE.

Function
REQ-019 Command accepted on a rising edge with cmd_valid and cmd_ready high; cmd_ready SHALL equal (fifo count < DEPTH), with no dependence on the same-cycle pop (no full-bypass).
REQ-020 FIFO SHALL be in-order; push and pop in the same cycle SHALL leave count unchanged; no empty-bypass.
REQ-021 FSM states IDLE, DRIVE, HOLD.
REQ-022 IDLE: if FIFO non-empty, pop head into alu_a/alu_b/alu_s, clear settle counter, go to DRIVE; else stay.
REQ-023 DRIVE: increment counter each cycle; on the SETTLE-th DRIVE cycle, capture alu_r into rsp_r and alu_s into rsp_op, set rsp_valid, go to HOLD.
REQ-024 Capture SHALL force rsp_r[7:4] to 0 when alu_s != MUL.
REQ-025 HOLD: rsp_valid, rsp_r and rsp_op SHALL be stable until rsp_valid and rsp_ready are both high at an edge; then clear rsp_valid and go to IDLE.
REQ-026 Latency: with an empty FIFO and an IDLE FSM, rsp_valid SHALL first be high after the (SETTLE+2)-th rising edge, counting the accepting edge as the first.
REQ-027 alu_a/alu_b/alu_s SHALL hold their last values outside DRIVE.
REQ-028 Commands arriving while busy SHALL queue; throughput is one result per SETTLE+2 cycles with rsp_ready held high.

Reset
REQ-029 While reset is asserted: FIFO empty, FSM IDLE, counter 0, alu_a=0, alu_b=0, alu_s=0, rsp_r=0, rsp_op=0, rsp_valid=0, cmd_ready=1, busy=0, all without waiting for a clock edge.
REQ-030 Reset mid-operation SHALL discard queued commands and any pending response; no response from before reset SHALL appear afterwards.

Structure
REQ-031 Shared package alu_pkg SHALL hold the opcode enum (values per REQ-007), the FSM state enum, and the width constants (4-bit operand, 8-bit result, 3-bit opcode).
REQ-032 The FIFO SHALL be one sub-module, alu_cmd_fifo (DEPTH, 11-bit entry {op,a,b}, full/empty/count).
REQ-033 The ALU SHALL be external; this block only drives it and samples it.

Verification (bench connects the existing 4-bit ALU; SETTLE=1, DEPTH=4)
REQ-034 MUL a=F b=F, rsp_ready=1 -> rsp_r=8'hE1, rsp_op=011, rsp_valid high after the 3rd edge counting the accepting edge as the first.
REQ-035 ADD a=9 b=8 -> rsp_r=8'h01; SUB a=3 b=5 -> rsp_r=8'h0E; responses appear in issue order.
REQ-036 rsp_ready=0, present 6 back-to-back commands -> 5 accepted (1 in HOLD, 4 in FIFO), cmd_ready low on the 6th; rsp_r stable across stall; raising rsp_ready drains all 5 in order.
REQ-037 Push on the same edge as an IDLE pop with FIFO at count 1 -> count unchanged, no lost or duplicated command.
REQ-038 Assert reset during HOLD with 3 queued -> rsp_valid, busy and all outputs go to 0 immediately, cmd_ready=1; no stale response after release.
